// File: rtl/ecc_fifo_pkg.sv
// Shared SECDED helpers for ecc_sync_fifo: code sizing, encoder, position mapping, decode result.
// Codeword layout: bit 0 = overall parity, Hamming check bits at power-of-two positions, data elsewhere.
package ecc_fifo_pkg;

  // Upper bound on payload width supported by the generic encoder.
  localparam int MAX_DATA_W = 256;
  localparam int MAX_P      = 9;
  localparam int MAX_ECC_W  = MAX_DATA_W + MAX_P + 1;

  typedef enum logic [1:0] {
    CLEAN = 2'd0,
    SEC   = 2'd1,
    DED   = 2'd2
  } dec_result_e;

  function automatic int calc_p(input int dw);
    int p;
    p = 0;
    for (int i = 1; i < 31; i++) begin
      if (p == 0 && (1 << i) >= dw + i + 1) p = i;
    end
    return p;
  endfunction

  function automatic int calc_ecc_width(input int dw);
    return dw + calc_p(dw) + 1;
  endfunction

  function automatic logic is_data_pos(input int pos);
    return (pos > 0) && ((pos & (pos - 1)) != 0);
  endfunction

  function automatic int flog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((v >> i) != 0) r = i;
    end
    return r;
  endfunction

  // Codeword position -> payload bit index (valid only where is_data_pos is true).
  function automatic int data_index(input int pos);
    return pos - flog2(pos) - 2;
  endfunction

  function automatic logic [MAX_ECC_W-1:0] secded_encode(input logic [MAX_DATA_W-1:0] data,
                                                         input int dw);
    logic [MAX_ECC_W-1:0] cw;
    int n;
    int syn;
    cw  = '0;
    n   = dw + calc_p(dw);
    syn = 0;
    for (int pos = 1; pos < MAX_ECC_W; pos++) begin
      if (pos <= n && is_data_pos(pos)) begin
        cw[pos] = data[data_index(pos)];
        if (cw[pos]) syn = syn ^ pos;
      end
    end
    // Check bits cancel the data syndrome so a clean word decodes to syndrome 0.
    for (int j = 0; j < MAX_P; j++) begin
      if ((1 << j) <= n) cw[1 << j] = syn[j];
    end
    cw[0] = ^cw;
    return cw;
  endfunction

endpackage

// File: rtl/ecc_sync_fifo_secded_decoder.sv
// Combinational SECDED decoder: corrects single-bit faults, flags double-bit faults.
module secded_decoder
  import ecc_fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = 64,
  localparam int P          = calc_p(DATA_WIDTH),
  localparam int ECC_WIDTH  = DATA_WIDTH + P + 1
) (
  input  logic [ECC_WIDTH-1:0]  cw,
  output logic [DATA_WIDTH-1:0] data,
  output dec_result_e           result
);

  logic [P-1:0] syn;
  logic         par;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    syn = '0;
    par = ^cw;
    for (int pos = 1; pos < ECC_WIDTH; pos++) begin
      if (cw[pos]) syn = syn ^ P'(pos);
    end

    result = CLEAN;
    if (par)             result = SEC;
    else if (syn != '0)  result = DED;

    // Only a parity-bad word is corrected; a check-bit hit leaves the payload alone.
    data = '0;
    for (int pos = 1; pos < ECC_WIDTH; pos++) begin
      if (is_data_pos(pos)) data[data_index(pos)] = cw[pos] ^ (par && (syn == P'(pos)));
    end
  end

endmodule

// File: rtl/ecc_sync_fifo.sv
// Single-clock SECDED-protected FIFO with threshold flags, over/underflow pulses and error counters.
// Define ECC_FAULT_INJECT_EN to add the InjEn/InjMask write-side fault injection ports.
module ecc_sync_fifo
  import ecc_fifo_pkg::*;
#(
  parameter  int DATA_WIDTH    = 64,
  parameter  int FIFO_DEPTH    = 128,
  parameter  int AFULL_THRESH  = FIFO_DEPTH - 4,
  parameter  int AEMPTY_THRESH = 4,
  parameter  int CNT_WIDTH     = 8,
  localparam int ADDR_WIDTH    = $clog2(FIFO_DEPTH),
  localparam int ECC_WIDTH     = calc_ecc_width(DATA_WIDTH)
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  WriteEn,
  input  logic [DATA_WIDTH-1:0] DataIn,
  input  logic                  ReadEn,
  input  logic                  CountClr,
`ifdef ECC_FAULT_INJECT_EN
  input  logic                  InjEn,
  input  logic [ECC_WIDTH-1:0]  InjMask,
`endif
  output logic [DATA_WIDTH-1:0] DataOut,
  output logic                  DataValid,
  output logic                  Empty,
  output logic                  Full,
  output logic                  AlmostEmpty,
  output logic                  AlmostFull,
  output logic [ADDR_WIDTH:0]   Level,
  output logic                  Overflow,
  output logic                  Underflow,
  output logic                  SingleErr,
  output logic                  DoubleErr,
  output logic [CNT_WIDTH-1:0]  SecCount,
  output logic [CNT_WIDTH-1:0]  DedCount,
  output logic                  DedSticky
);

  localparam int                  LW      = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = LW'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_L    = LW'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_L    = LW'(AEMPTY_THRESH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic                  wr_ok, rd_ok;
  logic [ECC_WIDTH-1:0]  wr_cw;
  logic [ECC_WIDTH-1:0]  mem [FIFO_DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   level_q, level_d;
  logic                  empty_q, empty_d, full_q, full_d;
  logic                  aempty_q, aempty_d, afull_q, afull_d;
  logic [ECC_WIDTH-1:0]  rd_cw_q, rd_cw_d;
  logic                  rd_vld_q, rd_vld_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  dvalid_q, dvalid_d, serr_q, serr_d, derr_q, derr_d;
  logic                  ovf_q, ovf_d, udf_q, udf_d;
  logic [CNT_WIDTH-1:0]  sec_cnt_q, sec_cnt_d, ded_cnt_q, ded_cnt_d;
  logic                  ded_sticky_q, ded_sticky_d;

  logic [DATA_WIDTH-1:0] dec_data;
  dec_result_e           dec_result;

  assign wr_ok = WriteEn && !full_q;
  assign rd_ok = ReadEn && !empty_q;

`ifdef ECC_FAULT_INJECT_EN
  assign wr_cw = ECC_WIDTH'(secded_encode(MAX_DATA_W'(DataIn), DATA_WIDTH)) ^ (InjEn ? InjMask : '0);
`else
  assign wr_cw = ECC_WIDTH'(secded_encode(MAX_DATA_W'(DataIn), DATA_WIDTH));
`endif

  // NOTE: storage is deliberately left out of reset; validity is tracked by the pointers alone.
  always_ff @(posedge Clock) begin
    if (wr_ok) mem[wr_ptr_q] <= wr_cw;
  end

  secded_decoder #(.DATA_WIDTH(DATA_WIDTH)) u_dec (
    .cw     (rd_cw_q),
    .data   (dec_data),
    .result (dec_result)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    rd_cw_d  = rd_cw_q;
    rd_vld_d = rd_ok;
    if (wr_ok) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
      rd_cw_d  = mem[rd_ptr_q];
    end
    case ({wr_ok, rd_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    empty_d  = (level_d == '0);
    full_d   = (level_d == DEPTH_L);
    aempty_d = (level_d <= AE_L);
    afull_d  = (level_d >= AF_L);
    ovf_d    = WriteEn && full_q;
    udf_d    = ReadEn && empty_q;

    // Second read stage: the codeword fetched last edge is decoded and registered.
    dout_d   = rd_vld_q ? dec_data : dout_q;
    dvalid_d = rd_vld_q;
    serr_d   = rd_vld_q && (dec_result == SEC);
    derr_d   = rd_vld_q && (dec_result == DED);

    sec_cnt_d    = sec_cnt_q;
    ded_cnt_d    = ded_cnt_q;
    ded_sticky_d = ded_sticky_q || derr_d;
    if (serr_d && sec_cnt_q != CNT_MAX) sec_cnt_d = sec_cnt_q + CNT_WIDTH'(1);
    if (derr_d && ded_cnt_q != CNT_MAX) ded_cnt_d = ded_cnt_q + CNT_WIDTH'(1);
    if (CountClr) begin
      sec_cnt_d    = '0;
      ded_cnt_d    = '0;
      ded_sticky_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      empty_q      <= 1'b1;
      full_q       <= 1'b0;
      aempty_q     <= 1'b1;
      afull_q      <= 1'b0;
      rd_cw_q      <= '0;
      rd_vld_q     <= 1'b0;
      dout_q       <= '0;
      dvalid_q     <= 1'b0;
      serr_q       <= 1'b0;
      derr_q       <= 1'b0;
      ovf_q        <= 1'b0;
      udf_q        <= 1'b0;
      sec_cnt_q    <= '0;
      ded_cnt_q    <= '0;
      ded_sticky_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      empty_q      <= empty_d;
      full_q       <= full_d;
      aempty_q     <= aempty_d;
      afull_q      <= afull_d;
      rd_cw_q      <= rd_cw_d;
      rd_vld_q     <= rd_vld_d;
      dout_q       <= dout_d;
      dvalid_q     <= dvalid_d;
      serr_q       <= serr_d;
      derr_q       <= derr_d;
      ovf_q        <= ovf_d;
      udf_q        <= udf_d;
      sec_cnt_q    <= sec_cnt_d;
      ded_cnt_q    <= ded_cnt_d;
      ded_sticky_q <= ded_sticky_d;
    end
  end

  assign DataOut     = dout_q;
  assign DataValid   = dvalid_q;
  assign Empty       = empty_q;
  assign Full        = full_q;
  assign AlmostEmpty = aempty_q;
  assign AlmostFull  = afull_q;
  assign Level       = level_q;
  assign Overflow    = ovf_q;
  assign Underflow   = udf_q;
  assign SingleErr   = serr_q;
  assign DoubleErr   = derr_q;
  assign SecCount    = sec_cnt_q;
  assign DedCount    = ded_cnt_q;
  assign DedSticky   = ded_sticky_q;

endmodule
